// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU PC/fetch datapath: default widths,
// the PC source select encoding and a PC alignment helper.
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int PC_INC  = 2;

    // Source of the next fetch address. Encoding 3 is reserved and behaves as sequential.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_JUMP_I = 2'd1,
        PC_JUMP_R = 2'd2,
        PC_RSVD   = 2'd3
    } pc_sel_e;

    // Instructions are halfword aligned; the low address bit is always cleared.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/cpu_pc_fetch_if.sv
// Bundle of fetch-control, imem pc-port and decode-side signals around the
// PC/fetch datapath. The slave modport is the datapath itself; the master
// modport is the surrounding environment (fetch control, imem, decode).
interface cpu_pc_fetch_if #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) ();
    logic                i_pc_rd;
    logic [1:0]          i_pc_addr_sel;
    logic [ADDR_W-1:0]   i_jump_i_target;
    logic [ADDR_W-1:0]   i_jump_r_target;
    logic [ADDR_W-1:0]   o_pc_addr;
    logic                o_pc_rd;
    logic [INSTR_W-1:0]  i_pc_rddata;
    logic [INSTR_W-1:0]  o_de_instr;
    logic [ADDR_W-1:0]   o_de_pc;
    logic                o_de_valid;
    logic                i_stall;

    modport master (
        output i_pc_rd, i_pc_addr_sel, i_jump_i_target, i_jump_r_target,
               i_pc_rddata, i_stall,
        input  o_pc_addr, o_pc_rd, o_de_instr, o_de_pc, o_de_valid
    );

    modport slave (
        input  i_pc_rd, i_pc_addr_sel, i_jump_i_target, i_jump_r_target,
               i_pc_rddata, i_stall,
        output o_pc_addr, o_pc_rd, o_de_instr, o_de_pc, o_de_valid
    );
endinterface

// File: rtl/cpu_fetch_hold.sv
// One-entry instruction hold register used while decode is stalled.
// The imem output is only trustworthy on the first stalled cycle (it holds the
// last real read); that word is captured and replayed for the rest of the stall.
module cpu_fetch_hold #(
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               stall,
    input  logic [INSTR_W-1:0] rddata,
    output logic [INSTR_W-1:0] instr
);
    logic               stall_reg;
    logic [INSTR_W-1:0] hold_reg;

    // Capture the live imem word on the first stalled cycle and track stall history.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_reg <= 1'b0;
            hold_reg  <= '0;
        end else begin
            stall_reg <= stall;
            if (stall && !stall_reg) begin
                hold_reg <= rddata;
            end
        end
    end

    // From the second stalled cycle on, decode sees the held word.
    always_comb begin
        instr = rddata;
        if (stall && stall_reg) begin
            instr = hold_reg;
        end
    end
endmodule

// File: rtl/cpu_pc_fetch.sv
// PC/fetch datapath: selects the fetch address, drives the imem pc port,
// tags returning instructions with their PC and marks them live for decode.
// The slot fetched alongside a register jump resolved in EX is wrong-path and
// is squashed. Optional decode stall support is enabled by CPU_FETCH_STALL_EN.
module cpu_pc_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int PC_INC  = cpu_pkg::PC_INC
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    cpu_pc_fetch_if.slave bus
);
    logic               run_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic [ADDR_W-1:0]  de_pc_reg;
    logic               de_valid_reg;

    logic [ADDR_W-1:0]  pc_addr;
    logic               fetch;
    logic               redirect_r;
    logic               stall_eff;
    logic [INSTR_W-1:0] instr_raw;
    pc_sel_e            sel;

    assign sel        = pc_sel_e'(bus.i_pc_addr_sel);
    assign redirect_r = (sel == PC_JUMP_R);

`ifdef CPU_FETCH_STALL_EN
    // A register jump must redirect even while decode is stalled.
    assign stall_eff = bus.i_stall & ~redirect_r;

    cpu_fetch_hold #(
        .INSTR_W (INSTR_W)
    ) u_hold (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .stall     (stall_eff),
        .rddata    (bus.i_pc_rddata),
        .instr     (instr_raw)
    );
`else
    assign stall_eff = 1'b0;
    assign instr_raw = bus.i_pc_rddata;
`endif

    // Fetch address mux; reserved select falls back to the sequential PC.
    always_comb begin
        pc_addr = pc_reg;
        case (sel)
            PC_JUMP_I: pc_addr = ADDR_W'(bus.i_jump_i_target);
            PC_JUMP_R: pc_addr = ADDR_W'(bus.i_jump_r_target);
            default:   pc_addr = pc_reg;
        endcase
        pc_addr = {pc_addr[ADDR_W-1:1], 1'b0};
    end

    assign fetch = bus.i_pc_rd & run_reg & ~stall_eff;

    // PC, decode tag and live bit advance on each issued fetch; a stall freezes them.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            run_reg      <= 1'b0;
            pc_reg       <= '0;
            de_pc_reg    <= '0;
            de_valid_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (fetch) begin
                pc_reg       <= pc_addr + ADDR_W'(PC_INC);
                de_pc_reg    <= pc_addr;
                de_valid_reg <= 1'b1;
            end else if (!stall_eff) begin
                de_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.o_pc_addr  = pc_addr;
    assign bus.o_pc_rd    = fetch;
    assign bus.o_de_pc    = de_pc_reg;
    // The decode slot is wrong-path when a register jump is issued this cycle.
    assign bus.o_de_valid = de_valid_reg & ~(fetch & redirect_r);
    // Decode sees zero until fetching has started after reset.
    assign bus.o_de_instr = run_reg ? instr_raw : '0;
endmodule

// File: tb/tb_cpu_pc_fetch.sv
// Self-checking bench for cpu_pc_fetch: directed vector table, hand-written
// stall and reset sequences, and randomized traffic against a fetch model.
// Build with CPU_FETCH_STALL_EN defined to exercise the stall feature.
module tb_cpu_pc_fetch;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   step_no = 0;

    always #5 clk = ~clk;

    cpu_pc_fetch_if bus ();

    cpu_pc_fetch dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

`ifdef CPU_FETCH_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    // Content of instruction memory at a given byte address.
    function automatic logic [15:0] imem_word(input logic [15:0] a);
        return (a ^ 16'hC3A5) + {a[7:0], a[15:8]};
    endfunction

    // Imem model: one-cycle read latency; output is junk on cycles without a read.
    always @(posedge clk) begin
        if (bus.o_pc_rd) bus.i_pc_rddata <= imem_word(bus.o_pc_addr);
        else             bus.i_pc_rddata <= 16'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, step_no, act, exp);
        end
    endtask

    // Fetch model state, expressed as program-order facts.
    bit          m_running;
    logic [15:0] m_next_pc;
    bit          m_de_live;
    logic [15:0] m_de_pc;
    bit          m_fresh;
    bit          m_prev_s;
    bit          m_hold_ok;

    task automatic model_reset();
        m_running = 0; m_next_pc = 16'h0000; m_de_live = 0; m_de_pc = 16'h0000;
        m_fresh = 0; m_prev_s = 0; m_hold_ok = 0;
    endtask

    // Drive one cycle, check settled outputs against the model, advance model.
    task automatic model_step(input bit rd, input logic [1:0] sel, input logic [15:0] ti,
                              input logic [15:0] tr, input bit st);
        bit          s;
        logic [15:0] e_addr;
        bit          e_rd;
        bit          e_valid;
        bit          inst_ok;
        @(negedge clk);
        bus.i_pc_rd = rd; bus.i_pc_addr_sel = sel;
        bus.i_jump_i_target = ti; bus.i_jump_r_target = tr; bus.i_stall = st;
        #1;
        step_no++;
        s = STALL_EN && st && (sel != 2'd2);
        if (sel == 2'd1)      e_addr = ti & 16'hFFFE;
        else if (sel == 2'd2) e_addr = tr & 16'hFFFE;
        else                  e_addr = m_next_pc;
        e_rd    = rd && m_running && !s;
        e_valid = m_de_live && !(e_rd && sel == 2'd2);
        chk("pc_addr",  bus.o_pc_addr,  e_addr);
        chk("pc_rd",    bus.o_pc_rd,    e_rd);
        chk("de_valid", bus.o_de_valid, e_valid);
        chk("de_pc",    bus.o_de_pc,    m_de_pc);
        inst_ok = s ? (m_prev_s ? m_hold_ok : m_fresh) : m_fresh;
        if (m_running && inst_ok) chk("de_instr", bus.o_de_instr, imem_word(m_de_pc));
        $display("[TB] step %0d rd=%0b sel=%0d stall=%0b addr=%h pc_rd=%0b de_pc=%h de_valid=%0b",
                 step_no, rd, sel, st, bus.o_pc_addr, bus.o_pc_rd, bus.o_de_pc, bus.o_de_valid);
        if (s) begin
            if (!m_prev_s) m_hold_ok = m_fresh;
            m_fresh = 0;
        end else if (e_rd) begin
            m_de_live = 1; m_de_pc = e_addr; m_next_pc = e_addr + 16'd2; m_fresh = 1;
        end else begin
            m_de_live = 0; m_fresh = 0;
        end
        m_prev_s  = s;
        m_running = 1;
    endtask

    typedef struct {
        logic        rd;
        logic [1:0]  sel;
        logic [15:0] ti;
        logic [15:0] tr;
        logic [15:0] e_addr;
        logic        e_rd;
        logic        e_valid;
        logic [15:0] e_de_pc;
    } vec_t;

    vec_t tbl [20];

    initial begin
        // Directed vectors starting right after reset release.
        tbl[0]  = '{1'b1, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 2'd0, 16'h0000, 16'h0000, 16'h0002, 1'b1, 1'b1, 16'h0000};
        tbl[3]  = '{1'b1, 2'd0, 16'h0000, 16'h0000, 16'h0004, 1'b1, 1'b1, 16'h0002};
        tbl[4]  = '{1'b1, 2'd0, 16'h0000, 16'h0000, 16'h0006, 1'b1, 1'b1, 16'h0004};
        tbl[5]  = '{1'b1, 2'd1, 16'h0010, 16'h0000, 16'h0010, 1'b1, 1'b1, 16'h0006};
        tbl[6]  = '{1'b1, 2'd1, 16'h0040, 16'h0000, 16'h0040, 1'b1, 1'b1, 16'h0010};
        tbl[7]  = '{1'b1, 2'd0, 16'h0000, 16'h0000, 16'h0042, 1'b1, 1'b1, 16'h0040};
        tbl[8]  = '{1'b1, 2'd1, 16'h0010, 16'h0000, 16'h0010, 1'b1, 1'b1, 16'h0042};
        tbl[9]  = '{1'b1, 2'd0, 16'h0000, 16'h0000, 16'h0012, 1'b1, 1'b1, 16'h0010};
        tbl[10] = '{1'b1, 2'd2, 16'h0000, 16'h0100, 16'h0100, 1'b1, 1'b0, 16'h0012};
        tbl[11] = '{1'b1, 2'd0, 16'h0000, 16'h0000, 16'h0102, 1'b1, 1'b1, 16'h0100};
        tbl[12] = '{1'b1, 2'd1, 16'hFFFE, 16'h0000, 16'hFFFE, 1'b1, 1'b1, 16'h0102};
        tbl[13] = '{1'b1, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFE};
        tbl[14] = '{1'b1, 2'd1, 16'h0031, 16'h0000, 16'h0030, 1'b1, 1'b1, 16'h0000};
        tbl[15] = '{1'b1, 2'd2, 16'h0000, 16'h0077, 16'h0076, 1'b1, 1'b0, 16'h0030};
        tbl[16] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0078, 1'b0, 1'b1, 16'h0076};
        tbl[17] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0078, 1'b0, 1'b0, 16'h0076};
        tbl[18] = '{1'b1, 2'd3, 16'h0000, 16'h0000, 16'h0078, 1'b1, 1'b0, 16'h0076};
        tbl[19] = '{1'b1, 2'd0, 16'h0000, 16'h0000, 16'h007A, 1'b1, 1'b1, 16'h0078};

        bus.i_pc_rd = 0; bus.i_pc_addr_sel = 2'd0; bus.i_jump_i_target = '0;
        bus.i_jump_r_target = '0; bus.i_stall = 0; bus.i_pc_rddata = '0;
        model_reset();

        // Reset state.
        #12;
        chk("rst_pc_rd",    bus.o_pc_rd,    1'b0);
        chk("rst_de_valid", bus.o_de_valid, 1'b0);
        chk("rst_de_instr", bus.o_de_instr, 16'h0000);
        chk("rst_pc_addr",  bus.o_pc_addr,  16'h0000);
        chk("rst_de_pc",    bus.o_de_pc,    16'h0000);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed table, cross-checked by the model as well.
        for (int i = 0; i < 20; i++) begin
            model_step(tbl[i].rd, tbl[i].sel, tbl[i].ti, tbl[i].tr, 1'b0);
            chk("tbl_pc_addr",  bus.o_pc_addr,  tbl[i].e_addr);
            chk("tbl_pc_rd",    bus.o_pc_rd,    tbl[i].e_rd);
            chk("tbl_de_valid", bus.o_de_valid, tbl[i].e_valid);
            chk("tbl_de_pc",    bus.o_de_pc,    tbl[i].e_de_pc);
        end

`ifdef CPU_FETCH_STALL_EN
        // Three-cycle stall with decode holding pc 0x0020.
        model_step(1'b1, 2'd1, 16'h001E, 16'h0000, 1'b0);
        model_step(1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0);
        chk("stall_setup_de_pc", bus.o_de_pc, 16'h001E);
        model_step(1'b1, 2'd0, 16'h0000, 16'h0000, 1'b1);
        chk("stall_de_pc", bus.o_de_pc, 16'h0020);
        for (int k = 0; k < 2; k++) begin
            model_step(1'b1, 2'd0, 16'h0000, 16'h0000, 1'b1);
            chk("stall_pc_rd", bus.o_pc_rd, 1'b0);
            chk("stall_hold_instr", bus.o_de_instr, imem_word(16'h0020));
        end
        model_step(1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0);
        model_step(1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0);
        // Register jump issued during a stall still redirects and squashes.
        model_step(1'b1, 2'd2, 16'h0000, 16'h0200, 1'b1);
        chk("stall_redirect_rd", bus.o_pc_rd, 1'b1);
        model_step(1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            model_step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
                       16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
        end

        // Asynchronous reset mid-cycle clears outputs without waiting for a clock.
        @(negedge clk);
        bus.i_pc_rd = 1'b1; bus.i_pc_addr_sel = 2'd0; bus.i_stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc_rd",    bus.o_pc_rd,    1'b0);
        chk("arst_de_valid", bus.o_de_valid, 1'b0);
        chk("arst_de_instr", bus.o_de_instr, 16'h0000);
        chk("arst_pc_addr",  bus.o_pc_addr,  16'h0000);
        chk("arst_de_pc",    bus.o_de_pc,    16'h0000);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        model_step(1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0);
        chk("restart_idle", bus.o_pc_rd, 1'b0);
        model_step(1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0);
        chk("restart_addr", bus.o_pc_addr, 16'h0000);
        model_step(1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0);
        chk("restart_next", bus.o_pc_addr, 16'h0002);
        for (int n = 0; n < 50; n++) begin
            model_step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
                       16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
